rstring_tap_seq: RTL and testbench

Parametrised digital sequencer for the resistor-string tap multiplexer used by the brownout/undervoltage detector. It controls NCH independent trip channels, each selecting one of NTAPS string taps from a binary code. It replaces static decoded selects with registered break-before-make tap switching, a string warm-up delay, per-channel settling qualification and optional comparator-driven hysteresis. It sits between the digital trim/control registers and the analog rstring mux, in the dvdd domain, clocked by the on-chip oscillator.

---
 rtl/rstring_pkg.sv | 37 +++
 rtl/rstring_tap_seq_if.sv | 26 ++
 rtl/rstring_tap_chan.sv | 98 +++++++++
 rtl/rstring_tap_seq.sv | 73 +++++++
 tb/tb_rstring_tap_seq.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rstring_pkg.sv
// Shared types and helpers for the resistor-string tap sequencer:
// channel FSM states, channel index names, one-hot decode and saturating add.
package rstring_pkg;

    typedef enum logic [2:0] {
        OFF,
        BREAK,
        MAKE,
        SETTLE,
        STABLE
    } chan_state_t;

    localparam int CH_BROUT  = 0;
    localparam int CH_VUNDER = 1;

    // Widest legal string is 64 taps; indices carry one spare bit for the hysteresis sum.
    localparam int MAX_TAPS = 64;
    localparam int IDX_W    = 7;

    function automatic logic [MAX_TAPS-1:0] onehot(input logic [IDX_W-1:0] idx,
                                                   input int               ntaps);
        logic [MAX_TAPS-1:0] v;
        v = '0;
        if (int'(idx) < ntaps) v = MAX_TAPS'(1) << idx;
        return v;
    endfunction

    function automatic logic [IDX_W-1:0] sat_add(input logic [IDX_W-1:0] code,
                                                 input logic [IDX_W-1:0] off,
                                                 input logic [IDX_W-1:0] max_idx);
        logic [IDX_W:0] sum;
        sum = {1'b0, code} + {1'b0, off};
        if (sum > {1'b0, max_idx}) return max_idx;
        return sum[IDX_W-1:0];
    endfunction

endpackage

// File: rtl/rstring_tap_seq_if.sv
// Control/status bundle between the trim registers and the tap sequencer.
// master = register side, slave = sequencer.
interface rstring_tap_seq_if #(
    parameter int NTAPS = 8,
    parameter int NCH   = 2,
    parameter int SEL_W = $clog2(NTAPS)
);
    logic                   ena;
    logic [NCH*SEL_W-1:0]   sel_code;
    logic [NCH-1:0]         hyst_en;
    logic [NCH-1:0]         cmp_out;
    logic                   rstr_ena;
    logic [NCH*NTAPS-1:0]   tap_sel;
    logic [NCH-1:0]         settled;
    logic                   busy;

    modport master (
        output ena, sel_code, hyst_en, cmp_out,
        input  rstr_ena, tap_sel, settled, busy
    );

    modport slave (
        input  ena, sel_code, hyst_en, cmp_out,
        output rstr_ena, tap_sel, settled, busy
    );
endinterface

// File: rtl/rstring_tap_chan.sv
// One trip channel: effective-index compute, break-before-make FSM,
// settle qualification and the registered one-hot tap select.
module rstring_tap_chan
    import rstring_pkg::*;
#(
    parameter int NTAPS      = 8,
    parameter int SEL_W      = $clog2(NTAPS),
    parameter int SETTLE_CYC = 4,
    parameter int HYST_TAPS  = 1
) (
    input  logic             osc_ck,
    input  logic             rstn,
    input  logic             ena,
    input  logic             warm_done,
    input  logic [SEL_W-1:0] sel_code,
    input  logic             hyst_en,
    input  logic             cmp_out,
    output logic [NTAPS-1:0] tap_sel,
    output logic             settled,
    output logic             settled_nxt
);

    localparam int CNT_W = $clog2(SETTLE_CYC + 1);

    chan_state_t      state_p0, state_d;
    logic [SEL_W-1:0] cur_p0, cur_d;
    logic [CNT_W-1:0] cnt_p0, cnt_d;
    logic [NTAPS-1:0] tap_p0, tap_d;
    logic             settled_p0;
    logic [IDX_W-1:0] hyst_off;
    logic [SEL_W-1:0] eff;

    // Out-of-range codes and hysteresis overflow both clamp to the top tap.
    assign hyst_off = (hyst_en & cmp_out) ? IDX_W'(HYST_TAPS) : '0;
    assign eff      = SEL_W'(sat_add(IDX_W'(sel_code), hyst_off, IDX_W'(NTAPS - 1)));

    always_comb begin
        state_d = state_p0;
        cur_d   = cur_p0;
        cnt_d   = cnt_p0;
        tap_d   = tap_p0;
        if (!ena) begin
            state_d = OFF;
        end else begin
            case (state_p0)
                OFF:     if (warm_done) state_d = MAKE;
                BREAK:   state_d = MAKE;
                MAKE:    state_d = SETTLE;
                SETTLE: begin
                    if (eff != cur_p0)                          state_d = BREAK;
                    else if (cnt_p0 == CNT_W'(SETTLE_CYC - 1)) state_d = STABLE;
                    else                                        cnt_d   = cnt_p0 + CNT_W'(1);
                end
                STABLE:  if (eff != cur_p0) state_d = BREAK;
                default: state_d = OFF;
            endcase
        end
        // The code is sampled only on MAKE entry, so anything seen during BREAK is absorbed.
        case (state_d)
            MAKE: begin
                cur_d = eff;
                tap_d = NTAPS'(onehot(IDX_W'(eff), NTAPS));
            end
            OFF, BREAK: tap_d = '0;
            default:    tap_d = tap_p0;
        endcase
        if (state_d != SETTLE) cnt_d = '0;
    end

    assign settled_nxt = (state_d == STABLE);

    always_ff @(posedge osc_ck or negedge rstn) begin
        if (!rstn) begin
            state_p0   <= OFF;
            cnt_p0     <= '0;
            tap_p0     <= '0;
            settled_p0 <= 1'b0;
        end else begin
            state_p0   <= state_d;
            cnt_p0     <= cnt_d;
            tap_p0     <= tap_d;
            settled_p0 <= settled_nxt;
        end
    end

    // cur is only consulted after a MAKE has loaded it.
    always_ff @(posedge osc_ck) begin
        cur_p0 <= cur_d;
    end

    assign tap_sel = tap_p0;
    assign settled = settled_p0;

    a_onehot0: assert property (@(posedge osc_ck) disable iff (!rstn) $onehot0(tap_p0));
    a_bbm: assert property (@(posedge osc_ck) disable iff (!rstn)
        (tap_p0 != '0) |=> (tap_p0 == '0 || tap_p0 == $past(tap_p0)));

endmodule

// File: rtl/rstring_tap_seq.sv
// Resistor-string tap sequencer top: string warm-up counter and bias enable,
// NCH independent tap channels, and the aggregated busy flag.
module rstring_tap_seq
    import rstring_pkg::*;
#(
    parameter int NTAPS      = 8,
    parameter int SEL_W      = $clog2(NTAPS),
    parameter int NCH        = 2,
    parameter int WARM_CYC   = 16,
    parameter int SETTLE_CYC = 4,
    parameter int HYST_TAPS  = 1
) (
    input  logic             osc_ck,
    input  logic             rstn,
    rstring_tap_seq_if.slave bus
);

    localparam int WARM_W = $clog2(WARM_CYC + 1);

    logic [WARM_W-1:0]    warm_cnt_p0;
    logic                 rstr_ena_p0;
    logic                 busy_p0;
    logic                 warm_done;
    logic [NCH*NTAPS-1:0] tap_all;
    logic [NCH-1:0]       settled_all;
    logic [NCH-1:0]       settled_nxt;

    assign warm_done = (warm_cnt_p0 == WARM_W'(WARM_CYC));

    // Any low sample of ena discards warm-up progress, so a re-enable waits the full time.
    always_ff @(posedge osc_ck or negedge rstn) begin
        if (!rstn) begin
            warm_cnt_p0 <= '0;
            rstr_ena_p0 <= 1'b0;
            busy_p0     <= 1'b0;
        end else begin
            busy_p0 <= bus.ena & ~(&settled_nxt);
            if (!bus.ena) begin
                warm_cnt_p0 <= '0;
                rstr_ena_p0 <= 1'b0;
            end else begin
                rstr_ena_p0 <= 1'b1;
                if (!warm_done) warm_cnt_p0 <= warm_cnt_p0 + WARM_W'(1);
            end
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_chan
        rstring_tap_chan #(
            .NTAPS      (NTAPS),
            .SEL_W      (SEL_W),
            .SETTLE_CYC (SETTLE_CYC),
            .HYST_TAPS  (HYST_TAPS)
        ) u_chan (
            .osc_ck      (osc_ck),
            .rstn        (rstn),
            .ena         (bus.ena),
            .warm_done   (warm_done),
            .sel_code    (bus.sel_code[c*SEL_W +: SEL_W]),
            .hyst_en     (bus.hyst_en[c]),
            .cmp_out     (bus.cmp_out[c]),
            .tap_sel     (tap_all[c*NTAPS +: NTAPS]),
            .settled     (settled_all[c]),
            .settled_nxt (settled_nxt[c])
        );
    end

    assign bus.rstr_ena = rstr_ena_p0;
    assign bus.tap_sel  = tap_all;
    assign bus.settled  = settled_all;
    assign bus.busy     = busy_p0;

endmodule

// File: tb/tb_rstring_tap_seq.sv
// Bench for rstring_tap_seq: directed scenarios with fixed expectations plus a
// randomized run against a cycle-level reference model of the sequencing rules.
module tb_rstring_tap_seq;

    localparam int NTAPS      = 8;
    localparam int NCH        = 2;
    localparam int SEL_W      = 3;
    localparam int WARM_CYC   = 16;
    localparam int SETTLE_CYC = 4;
    localparam int HYST_TAPS  = 1;
    localparam int B = rstring_pkg::CH_BROUT;
    localparam int V = rstring_pkg::CH_VUNDER;

    logic osc_ck;
    logic rstn;
    int   checks;
    int   failures;

    rstring_tap_seq_if #(.NTAPS(NTAPS), .NCH(NCH), .SEL_W(SEL_W)) bus ();

    rstring_tap_seq #(
        .NTAPS(NTAPS), .SEL_W(SEL_W), .NCH(NCH),
        .WARM_CYC(WARM_CYC), .SETTLE_CYC(SETTLE_CYC), .HYST_TAPS(HYST_TAPS)
    ) dut (
        .osc_ck (osc_ck),
        .rstn   (rstn),
        .bus    (bus)
    );

    initial begin
        osc_ck = 1'b0;
        forever #5 osc_ck = ~osc_ck;
    end

    // Reference model: warm-up age, per-channel on/breaking flags, current tap, age since make.
    int                   m_warm;
    bit                   m_rstr;
    bit                   m_on  [NCH];
    bit                   m_brk [NCH];
    int                   m_cur [NCH];
    int                   m_age [NCH];
    logic [NCH*NTAPS-1:0] m_tap;
    logic [NCH-1:0]       m_settled;
    logic                 m_busy;

    function automatic int eff_of(int c);
        int e;
        e = int'(bus.sel_code[c*SEL_W +: SEL_W]);
        if (bus.hyst_en[c] && bus.cmp_out[c]) e = e + HYST_TAPS;
        if (e > NTAPS - 1) e = NTAPS - 1;
        return e;
    endfunction

    task automatic model_outputs();
        m_tap = '0;
        for (int c = 0; c < NCH; c++) begin
            if (m_on[c] && !m_brk[c]) m_tap[c*NTAPS + m_cur[c]] = 1'b1;
            m_settled[c] = m_on[c] && !m_brk[c] && (m_age[c] == SETTLE_CYC + 1);
        end
        m_busy = bus.ena && (m_settled != '1);
    endtask

    task automatic model_reset();
        m_warm = 0;
        m_rstr = 0;
        for (int c = 0; c < NCH; c++) begin
            m_on[c] = 0; m_brk[c] = 0; m_cur[c] = 0; m_age[c] = 0;
        end
        m_tap = '0; m_settled = '0; m_busy = 1'b0;
    endtask

    task automatic model_edge();
        bit wdone;
        int e;
        if (!bus.ena) begin
            m_warm = 0;
            m_rstr = 0;
            for (int c = 0; c < NCH; c++) begin
                m_on[c] = 0; m_brk[c] = 0; m_age[c] = 0;
            end
        end else begin
            wdone  = (m_warm == WARM_CYC);
            m_rstr = 1;
            if (m_warm < WARM_CYC) m_warm++;
            for (int c = 0; c < NCH; c++) begin
                e = eff_of(c);
                if (!m_on[c]) begin
                    if (wdone) begin m_on[c] = 1; m_cur[c] = e; m_age[c] = 0; end
                end else if (m_brk[c]) begin
                    m_brk[c] = 0; m_cur[c] = e; m_age[c] = 0;
                end else if (m_age[c] == 0) begin
                    m_age[c] = 1;
                end else if (e != m_cur[c]) begin
                    m_brk[c] = 1;
                end else if (m_age[c] <= SETTLE_CYC) begin
                    m_age[c]++;
                end
            end
        end
        model_outputs();
    endtask

    task automatic tick();
        @(posedge osc_ck);
        model_edge();
        #1;
    endtask

    task automatic set_code(int c, int v);
        bus.sel_code[c*SEL_W +: SEL_W] = SEL_W'(v);
    endtask

    function automatic logic [NTAPS-1:0] slice(int c);
        return bus.tap_sel[c*NTAPS +: NTAPS];
    endfunction

    // Structural invariant on every cycle: zero-or-one-hot and never hot-to-different-hot.
    logic [NTAPS-1:0] mon_prev [NCH];
    always @(negedge osc_ck) begin
        for (int c = 0; c < NCH; c++) begin
            checks++;
            if (!$onehot0(slice(c))) begin
                failures++;
                $display("FAIL onehot0 ch%0d got=%h exp=zero_or_onehot", c, slice(c));
            end
            checks++;
            if (mon_prev[c] != '0 && slice(c) != '0 && slice(c) != mon_prev[c]) begin
                failures++;
                $display("FAIL bbm ch%0d got=%h prev=%h exp=open_between", c, slice(c), mon_prev[c]);
            end
            mon_prev[c] = slice(c);
        end
    end

    task automatic test_reset();
        rstn = 1'b0;
        bus.ena = 1'b0; bus.sel_code = '0; bus.hyst_en = '0; bus.cmp_out = '0;
        model_reset();
        repeat (2) @(posedge osc_ck);
        #1;
        checks++; if (bus.tap_sel !== '0) begin failures++; $display("FAIL reset_tap got=%h exp=0", bus.tap_sel); end
        checks++; if (bus.rstr_ena !== 1'b0) begin failures++; $display("FAIL reset_rstr got=%b exp=0", bus.rstr_ena); end
        checks++; if (bus.settled !== '0) begin failures++; $display("FAIL reset_settled got=%b exp=0", bus.settled); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        #2 rstn = 1'b1;
        tick();
        checks++; if (bus.rstr_ena !== 1'b0) begin failures++; $display("FAIL idle_rstr got=%b exp=0", bus.rstr_ena); end
    endtask

    task automatic test_warmup();
        set_code(B, 3); set_code(V, 5);
        bus.ena = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            tick();
            if (k == 1) begin
                checks++; if (bus.rstr_ena !== 1'b1) begin failures++; $display("FAIL warm_rstr got=%b exp=1", bus.rstr_ena); end
            end
            if (k <= 16) begin
                checks++; if (bus.tap_sel !== '0) begin failures++; $display("FAIL warm_open k=%0d got=%h exp=0", k, bus.tap_sel); end
            end
            if (k == 16) begin
                checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL warm_busy got=%b exp=1", bus.busy); end
            end
            if (k == 17) begin
                checks++; if (bus.tap_sel !== 16'h2008) begin failures++; $display("FAIL warm_make got=%h exp=2008", bus.tap_sel); end
            end
            if (k == 21) begin
                checks++; if (bus.settled !== 2'b00) begin failures++; $display("FAIL warm_settle_early got=%b exp=00", bus.settled); end
            end
            if (k == 22) begin
                checks++; if (bus.settled !== 2'b11) begin failures++; $display("FAIL warm_settled got=%b exp=11", bus.settled); end
                checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL warm_idle_busy got=%b exp=0", bus.busy); end
            end
        end
    endtask

    task automatic test_break_before_make();
        set_code(B, 6);
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 1) begin
                checks++; if (slice(B) !== 8'h00) begin failures++; $display("FAIL bbm_break got=%h exp=00", slice(B)); end
            end
            if (j == 2) begin
                checks++; if (slice(B) !== 8'h40) begin failures++; $display("FAIL bbm_make got=%h exp=40", slice(B)); end
            end
            checks++;
            if (bus.settled[B] !== (j == 7)) begin
                failures++; $display("FAIL bbm_settled j=%0d got=%b exp=%b", j, bus.settled[B], (j == 7));
            end
            checks++;
            if (slice(V) !== 8'h20 || bus.settled[V] !== 1'b1) begin
                failures++; $display("FAIL bbm_other_ch got=%h/%b exp=20/1", slice(V), bus.settled[V]);
            end
        end
    endtask

    task automatic test_hysteresis();
        bus.hyst_en[V] = 1'b1; bus.cmp_out[V] = 1'b0; set_code(V, 7);
        repeat (7) tick();
        checks++; if (slice(V) !== 8'h80 || bus.settled[V] !== 1'b1) begin failures++; $display("FAIL hyst_top got=%h/%b exp=80/1", slice(V), bus.settled[V]); end
        bus.cmp_out[V] = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            if (slice(V) !== 8'h80 || bus.settled[V] !== 1'b1) begin
                failures++; $display("FAIL hyst_sat j=%0d got=%h/%b exp=80/1", j, slice(V), bus.settled[V]);
            end
        end
        bus.cmp_out[V] = 1'b0; set_code(V, 2);
        repeat (7) tick();
        checks++; if (slice(V) !== 8'h04 || bus.settled[V] !== 1'b1) begin failures++; $display("FAIL hyst_base got=%h/%b exp=04/1", slice(V), bus.settled[V]); end
        bus.cmp_out[V] = 1'b1;
        tick();
        checks++; if (slice(V) !== 8'h00) begin failures++; $display("FAIL hyst_break got=%h exp=00", slice(V)); end
        tick();
        checks++; if (slice(V) !== 8'h08) begin failures++; $display("FAIL hyst_make got=%h exp=08", slice(V)); end
        repeat (5) tick();
        checks++; if (bus.settled[V] !== 1'b1) begin failures++; $display("FAIL hyst_resettle got=%b exp=1", bus.settled[V]); end
    endtask

    task automatic test_abort();
        set_code(B, 1);
        for (int j = 1; j <= 4; j++) begin
            tick();
            checks++;
            if (slice(B) !== ((j == 1) ? 8'h00 : 8'h02)) begin
                failures++; $display("FAIL abort_first_tap j=%0d got=%h", j, slice(B));
            end
            checks++; if (bus.settled[B] !== 1'b0) begin failures++; $display("FAIL abort_first_settled j=%0d got=%b exp=0", j, bus.settled[B]); end
        end
        set_code(B, 4);
        for (int j = 1; j <= 7; j++) begin
            tick();
            if (j == 1) begin
                checks++; if (slice(B) !== 8'h00) begin failures++; $display("FAIL abort_break got=%h exp=00", slice(B)); end
            end
            if (j == 2) begin
                checks++; if (slice(B) !== 8'h10) begin failures++; $display("FAIL abort_make got=%h exp=10", slice(B)); end
            end
            checks++;
            if (bus.settled[B] !== (j == 7)) begin
                failures++; $display("FAIL abort_settled j=%0d got=%b exp=%b", j, bus.settled[B], (j == 7));
            end
        end
    endtask

    task automatic test_ena_drop();
        bus.hyst_en = '0; bus.cmp_out = '0; set_code(B, 4); set_code(V, 2);
        bus.ena = 1'b0;
        tick();
        checks++;
        if (bus.tap_sel !== '0 || bus.settled !== '0 || bus.rstr_ena !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL drop_outputs got=%h/%b/%b/%b exp=0/0/0/0", bus.tap_sel, bus.settled, bus.rstr_ena, bus.busy);
        end
        bus.ena = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (bus.tap_sel !== ((k == 17) ? 16'h0410 : 16'h0000)) begin
                failures++; $display("FAIL rewarm k=%0d got=%h", k, bus.tap_sel);
            end
        end
        bus.ena = 1'b0;
        tick();
        bus.ena = 1'b1;
        repeat (10) tick();
        bus.ena = 1'b0;
        tick();
        checks++;
        if (bus.rstr_ena !== 1'b0 || bus.busy !== 1'b0 || bus.tap_sel !== '0) begin
            failures++; $display("FAIL warm_toggle_off got=%b/%b/%h exp=0/0/0", bus.rstr_ena, bus.busy, bus.tap_sel);
        end
        bus.ena = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            checks++;
            if (bus.tap_sel !== ((k == 17) ? 16'h0410 : 16'h0000)) begin
                failures++; $display("FAIL warm_restart k=%0d got=%h", k, bus.tap_sel);
            end
        end
    endtask

    task automatic test_async_reset();
        tick();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (bus.tap_sel !== '0 || bus.settled !== '0 || bus.rstr_ena !== 1'b0 || bus.busy !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%h/%b/%b/%b exp=0/0/0/0", bus.tap_sel, bus.settled, bus.rstr_ena, bus.busy);
        end
        model_reset();
        #2 rstn = 1'b1;
        tick();
        checks++;
        if (bus.rstr_ena !== 1'b1 || bus.tap_sel !== '0) begin
            failures++; $display("FAIL post_reset_warm got=%b/%h exp=1/0", bus.rstr_ena, bus.tap_sel);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1200; i++) begin
            if ($urandom_range(0, 7) == 0) set_code(int'($urandom_range(0, NCH - 1)), int'($urandom_range(0, NTAPS - 1)));
            if ($urandom_range(0, 15) == 0) bus.hyst_en = NCH'($urandom);
            if ($urandom_range(0, 3) == 0) bus.cmp_out = NCH'($urandom);
            bus.ena = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
            tick();
            checks++; if (bus.tap_sel !== m_tap) begin failures++; $display("FAIL rnd_tap i=%0d got=%h exp=%h", i, bus.tap_sel, m_tap); end
            checks++; if (bus.settled !== m_settled) begin failures++; $display("FAIL rnd_settled i=%0d got=%b exp=%b", i, bus.settled, m_settled); end
            checks++; if (bus.busy !== m_busy) begin failures++; $display("FAIL rnd_busy i=%0d got=%b exp=%b", i, bus.busy, m_busy); end
            checks++; if (bus.rstr_ena !== m_rstr) begin failures++; $display("FAIL rnd_rstr i=%0d got=%b exp=%b", i, bus.rstr_ena, m_rstr); end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int c = 0; c < NCH; c++) mon_prev[c] = '0;
        test_reset();
        test_warmup();
        test_break_before_make();
        test_hysteresis();
        test_abort();
        test_ena_drop();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
